bist_scan_engine: RTL and testbench

//  Parametrised test-per-scan BIST engine wrapping an arbitrary single-chain scan CUT.

---
 rtl/bist_scan_engine_if.sv | 52 +++++
 rtl/bist_scan_engine.sv | 158 +++++++++++++++
 tb/tb_bist_scan_engine.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bist_scan_engine_if.sv
// bist_scan_engine_if
//   Groups the pin-side session handshake and the CUT-facing scan/IO
//   signals of bist_scan_engine.
//   slave  : the engine (drives CUT controls and session status)
//   master : chip pins / CUT side (drives start, pi, CUT responses)
//   Signals:
//     bist_start, pi, cut_po, cut_scan_out    master -> slave
//     cut_pi, cut_scan_en, cut_scan_in,
//     cut_reset, bist_running, bist_end,
//     pass_nfail                              slave -> master
//     misr_sig (BIST_SIG_READ_EN only)        slave -> master
//   Optional feature macro: BIST_SIG_READ_EN
interface bist_scan_engine_if #(
  parameter int PI_W = 4,
  parameter int PO_W = 4
`ifdef BIST_SIG_READ_EN
  , parameter int MISR_W = 9
`endif
) ();
  logic            bist_start;
  logic [PI_W-1:0] pi;
  logic [PO_W-1:0] cut_po;
  logic            cut_scan_out;
  logic [PI_W-1:0] cut_pi;
  logic            cut_scan_en;
  logic            cut_scan_in;
  logic            cut_reset;
  logic            bist_running;
  logic            bist_end;
  logic            pass_nfail;
`ifdef BIST_SIG_READ_EN
  logic [MISR_W-1:0] misr_sig;
`endif

  modport slave (
    input  bist_start, pi, cut_po, cut_scan_out,
    output cut_pi, cut_scan_en, cut_scan_in, cut_reset,
           bist_running, bist_end, pass_nfail
`ifdef BIST_SIG_READ_EN
    , output misr_sig
`endif
  );

  modport master (
    output bist_start, pi, cut_po, cut_scan_out,
    input  cut_pi, cut_scan_en, cut_scan_in, cut_reset,
           bist_running, bist_end, pass_nfail
`ifdef BIST_SIG_READ_EN
    , input misr_sig
`endif
  );
endinterface

// File: rtl/bist_scan_engine.sv
// bist_scan_engine
//   Test-per-scan BIST engine wrapping a single-chain scan CUT. One FSM
//   sequences INIT -> (SHIFT x SCAN_LEN, CAPTURE) x N_PATTERNS -> FLUSH ->
//   DONE, feeding the CUT from a Galois PI LFSR and a Fibonacci scan LFSR,
//   compacting PO + scan-out into a Galois MISR and comparing the final
//   signature against SIGNATURE.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous active-high reset, clears all state
//     bus    bist_scan_engine_if.slave (session handshake + CUT side)
//   Optional feature macro: BIST_SIG_READ_EN -- exposes the live MISR as
//   bus.misr_sig (frozen in DONE for diagnosis).
module bist_scan_engine #(
  parameter int                  PI_W       = 4,
  parameter int                  PO_W       = 4,
  parameter int                  SCAN_LEN   = 8,
  parameter int                  N_PATTERNS = 16,
  parameter int                  MISR_W     = 9,
  parameter logic [MISR_W-1:0]   MISR_POLY  = 9'h011,
  parameter logic [PI_W-1:0]     PI_POLY    = 4'h9,
  parameter logic [PI_W-1:0]     PI_SEED    = 4'h1,
  parameter logic [SCAN_LEN-1:0] SC_POLY    = 8'hB8,
  parameter logic [SCAN_LEN-1:0] SC_SEED    = 8'h01,
  parameter logic [MISR_W-1:0]   SIGNATURE  = 9'h08c
) (
  input  logic               clock,
  input  logic               reset,
  bist_scan_engine_if.slave  bus
);

  localparam int SC_CW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int PC_W  = $clog2(N_PATTERNS + 1);
  localparam logic [SC_CW-1:0] SHIFT_LAST = SC_CW'(SCAN_LEN - 1);
  localparam logic [PC_W-1:0]  PAT_LAST   = PC_W'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SHIFT, S_CAPTURE, S_FLUSH, S_DONE
  } state_t;

  state_t              state;
  logic [SC_CW-1:0]    shift_cnt;
  logic [PC_W-1:0]     pat_cnt;
  logic [SCAN_LEN-1:0] sc_lfsr, sc_nx;
  logic [PI_W-1:0]     pi_lfsr, pi_nx;
  logic [MISR_W-1:0]   misr, misr_nx, misr_inj;
  logic                sc_fb;
  logic                running_q, scan_en_q, end_q, pass_q;

  // Scan LFSR: parity of tapped bits enters at bit 0, so the bit presented
  // on cut_scan_in is always the most recently generated one.
  assign sc_fb = ^(sc_lfsr & SC_POLY);

  generate
    if (SCAN_LEN == 1) begin : g_sc1
      assign sc_nx = sc_fb;
    end else begin : g_scn
      assign sc_nx = {sc_lfsr[SCAN_LEN-2:0], sc_fb};
    end
    if (PI_W == 1) begin : g_pi1
      assign pi_nx = pi_lfsr[0] ? PI_POLY : '0;
    end else begin : g_pin
      assign pi_nx = {pi_lfsr[PI_W-2:0], 1'b0} ^ (pi_lfsr[PI_W-1] ? PI_POLY : '0);
    end
  endgenerate

  // MISR input is {cut_po, cut_scan_out} zero-extended to MISR_W.
  always_comb begin
    misr_inj = '0;
    misr_inj[PO_W:0] = {bus.cut_po, bus.cut_scan_out};
    misr_nx = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : '0) ^ misr_inj;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      sc_lfsr   <= SC_SEED;
      pi_lfsr   <= PI_SEED;
      misr      <= '0;
      running_q <= 1'b0;
      scan_en_q <= 1'b0;
      end_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        // DONE holds the result until a new request arrives; a request in
        // DONE starts the next session directly (back-to-back).
        S_IDLE, S_DONE: begin
          if (bus.bist_start) begin
            state     <= S_INIT;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            sc_lfsr   <= SC_SEED;
            pi_lfsr   <= PI_SEED;
            misr      <= '0;
            pass_q    <= 1'b0;
            running_q <= 1'b1;
            scan_en_q <= 1'b0;
            end_q     <= 1'b0;
          end
        end
        // CUT is held in reset for this cycle via cut_reset.
        S_INIT: begin
          state     <= S_SHIFT;
          scan_en_q <= 1'b1;
        end
        S_SHIFT: begin
          misr    <= misr_nx;
          sc_lfsr <= sc_nx;
          if (shift_cnt == SHIFT_LAST) begin
            shift_cnt <= '0;
            state     <= S_CAPTURE;
            scan_en_q <= 1'b0;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        // PI vector advances on the capture edge, so cut_pi is stable for
        // the whole shift window and the capture cycle of each pattern.
        S_CAPTURE: begin
          misr      <= misr_nx;
          pi_lfsr   <= pi_nx;
          scan_en_q <= 1'b1;
          pat_cnt   <= pat_cnt + 1'b1;
          state     <= (pat_cnt == PAT_LAST) ? S_FLUSH : S_SHIFT;
        end
        // Unload the last captured response; scan LFSR is frozen.
        S_FLUSH: begin
          misr <= misr_nx;
          if (shift_cnt == SHIFT_LAST) begin
            shift_cnt <= '0;
            state     <= S_DONE;
            scan_en_q <= 1'b0;
            running_q <= 1'b0;
            end_q     <= 1'b1;
            pass_q    <= (misr_nx == SIGNATURE);
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cut_pi       = running_q ? pi_lfsr : bus.pi;
  assign bus.cut_scan_en  = scan_en_q;
  assign bus.cut_scan_in  = sc_lfsr[0];
  assign bus.cut_reset    = reset | (state == S_INIT);
  assign bus.bist_running = running_q;
  assign bus.bist_end     = end_q;
  assign bus.pass_nfail   = pass_q;
`ifdef BIST_SIG_READ_EN
  assign bus.misr_sig     = misr;
`endif

endmodule

// File: tb/tb_bist_scan_engine.sv
// tb_bist_scan_engine
//   Directed bench for bist_scan_engine with a small behavioural scan CUT.
//   The golden signature is derived by a constant function that walks one
//   whole session of the CUT + pattern sources, and is handed to the DUT as
//   its SIGNATURE parameter.
module tb_bist_scan_engine;
  localparam int PI_W = 4;
  localparam int PO_W = 4;
  localparam int MW   = 9;

  // ---- CUT behaviour (shared by the live CUT and the session model) ----
  function automatic logic [3:0] po_f(input logic [3:0] p, input logic [7:0] ch);
    return ch[7:4] ^ p;
  endfunction

  function automatic logic [7:0] cap_f(input logic [3:0] p, input logic [7:0] ch);
    return {ch[6:0], ch[7]} ^ {p, ~p};
  endfunction

  function automatic logic [8:0] misr_step(input logic [8:0] m, input logic [3:0] po,
                                           input logic so);
    return {m[7:0], 1'b0} ^ (m[8] ? 9'h011 : 9'h000) ^ {4'b0000, po, so};
  endfunction

  // One full session: 16 x (8 shifts + capture) then 8 flush shifts.
  function automatic logic [8:0] model_sig(input bit stuck);
    logic [7:0] sc, ch;
    logic [3:0] pl;
    logic [8:0] m;
    sc = 8'h01; pl = 4'h1; m = '0; ch = '0;
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 8; s++) begin
        m  = misr_step(m, po_f(pl, ch), stuck ? 1'b0 : ch[7]);
        ch = {ch[6:0], sc[0]};
        sc = {sc[6:0], ^(sc & 8'hB8)};
      end
      m  = misr_step(m, po_f(pl, ch), stuck ? 1'b0 : ch[7]);
      ch = cap_f(pl, ch);
      pl = {pl[2:0], 1'b0} ^ (pl[3] ? 4'h9 : 4'h0);
    end
    for (int s = 0; s < 8; s++) begin
      m  = misr_step(m, po_f(pl, ch), stuck ? 1'b0 : ch[7]);
      ch = {ch[6:0], sc[0]};
    end
    return m;
  endfunction

  localparam logic [8:0] SIG_GOLD  = model_sig(1'b0);
  localparam logic [8:0] SIG_STUCK = model_sig(1'b1);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bist_scan_engine_if #(
    .PI_W(PI_W), .PO_W(PO_W)
`ifdef BIST_SIG_READ_EN
    , .MISR_W(MW)
`endif
  ) bus ();

  bist_scan_engine #(.SIGNATURE(SIG_GOLD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---- live CUT ----
  logic [7:0] chain;
  logic       stuck;
  always_ff @(posedge clock) begin
    if (bus.cut_reset)        chain <= '0;
    else if (bus.cut_scan_en) chain <= {chain[6:0], bus.cut_scan_in};
    else                      chain <= cap_f(bus.cut_pi, chain);
  end
  assign bus.cut_po       = po_f(bus.cut_pi, chain);
  assign bus.cut_scan_out = stuck ? 1'b0 : chain[7];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---- session observation ----
  int         cyc, en_cnt, pi_chg, pi_bad;
  logic [7:0] sin_bits;
  logic [3:0] cap_log [0:4];
  bit         hold_start = 0;

  // Pulses (or holds) bist_start and watches the session cycle by cycle.
  // cyc counts clock edges after the start edge; stops at bist_end, at
  // abort_at (if nonzero) or at a 400-cycle bound.
  task automatic run_session(input int abort_at);
    logic       prev_run, prev_cap, is_cap;
    logic [3:0] prev_pi;
    int         ncap, nsh;
    cyc = 0; en_cnt = 0; pi_chg = 0; pi_bad = 0; sin_bits = '0; ncap = 0; nsh = 0;
    for (int i = 0; i < 5; i++) cap_log[i] = 'x;
    @(negedge clock); bus.bist_start = 1'b1;
    @(posedge clock);
    @(negedge clock); bus.bist_start = hold_start;
    prev_run = bus.bist_running; prev_pi = bus.cut_pi; prev_cap = 1'b0;
    while (cyc <= 400) begin
      @(posedge clock); cyc++;
      @(negedge clock);
      if (bus.bist_end || (abort_at != 0 && cyc == abort_at)) break;
      if (bus.cut_scan_en) begin
        en_cnt++;
        if (nsh < 8) begin sin_bits[nsh] = bus.cut_scan_in; nsh++; end
      end
      is_cap = bus.bist_running && !bus.cut_scan_en && !bus.cut_reset;
      if (is_cap) begin
        if (ncap < 5) cap_log[ncap] = bus.cut_pi;
        ncap++;
      end
      if (prev_run && bus.bist_running && bus.cut_pi != prev_pi) begin
        pi_chg++;
        if (!prev_cap) pi_bad++;
      end
      prev_run = bus.bist_running; prev_pi = bus.cut_pi; prev_cap = is_cap;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_running"}, bus.bist_running, 1'b0);
    chk({tag, "_end"},     bus.bist_end,     1'b0);
    chk({tag, "_pass"},    bus.pass_nfail,   1'b0);
    chk({tag, "_scan_en"}, bus.cut_scan_en,  1'b0);
    chk({tag, "_cut_rst"}, bus.cut_reset,    1'b1);
    chk({tag, "_cut_pi"},  bus.cut_pi,       bus.pi);
  endtask

  initial begin
    int n;
    reset = 1'b1; stuck = 1'b0; bus.bist_start = 1'b0; bus.pi = 4'hA;
    #12;
    chk_reset_outputs("por");
    @(negedge clock); reset = 1'b0;
    @(negedge clock); bus.pi = 4'h3;
    #1;
    chk("idle_cut_rst", bus.cut_reset, 1'b0);
    chk("idle_cut_pi",  bus.cut_pi,    4'h3);
    chk("idle_end",     bus.bist_end,  1'b0);

    // Golden session
    run_session(0);
    chk("gold_cycles",  cyc,            153);
    chk("gold_pass",    bus.pass_nfail, 1'b1);
    chk("gold_scan_en", en_cnt,         136);
    chk("gold_pi_chg",  pi_chg,         16);
    chk("gold_pi_when", pi_bad,         0);
    chk("gold_scan_in", sin_bits,       8'h71);
    chk("gold_cap0",    cap_log[0],     4'h1);
    chk("gold_cap1",    cap_log[1],     4'h2);
    chk("gold_cap2",    cap_log[2],     4'h4);
    chk("gold_cap3",    cap_log[3],     4'h8);
    chk("gold_cap4",    cap_log[4],     4'h9);
`ifdef BIST_SIG_READ_EN
    chk("gold_misr",    bus.misr_sig,   SIG_GOLD);
`endif
    repeat (3) @(negedge clock);
    chk("done_end_held", bus.bist_end,     1'b1);
    chk("done_running",  bus.bist_running, 1'b0);
    chk("done_cut_pi",   bus.cut_pi,       bus.pi);
    chk("done_scan_en",  bus.cut_scan_en,  1'b0);

    // Scan-out stuck-at-0
    stuck = 1'b1;
    run_session(0);
    chk("stuck_cycles", cyc,            153);
    chk("stuck_pass",   bus.pass_nfail, (SIG_STUCK == SIG_GOLD));
`ifdef BIST_SIG_READ_EN
    chk("stuck_misr",   bus.misr_sig,   SIG_STUCK);
`endif
    stuck = 1'b0;

    // Reset in the middle of a shift window, then rerun
    run_session(50);
    chk("abort_reached", cyc, 50);
    chk("abort_in_shift", bus.cut_scan_en, 1'b1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("abort");
    @(posedge clock); @(negedge clock); reset = 1'b0;
    run_session(0);
    chk("rerun_cycles", cyc,            153);
    chk("rerun_pass",   bus.pass_nfail, 1'b1);
`ifdef BIST_SIG_READ_EN
    chk("rerun_misr",   bus.misr_sig,   SIG_GOLD);
`endif

    // bist_start held high: back-to-back sessions
    hold_start = 1;
    run_session(0);
    chk("hold1_cycles", cyc,            153);
    chk("hold1_pass",   bus.pass_nfail, 1'b1);
    n = 0;
    while (n <= 400) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (n == 1) chk("hold_end_pulse", bus.bist_end, 1'b0);
      if (bus.bist_end) break;
    end
    chk("hold2_period", n,              154);
    chk("hold2_pass",   bus.pass_nfail, 1'b1);
    bus.bist_start = 1'b0;
    hold_start = 0;
    repeat (2) @(negedge clock);
    chk("hold_done_held", bus.bist_end, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
